serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
//  Inverse operation to the team's ripple adders.
//  - Trades latency for area: a single one-bit full_subtractor cell plus a borrow flop.
//  - Sits beside the adder datapath in the ALU exercises.
//  - Hands results to downstream logic via a start/busy/done handshake.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request: capture a,b and begin subtraction
//  a           in   WIDTH  minuend (unsigned, or two's complement)
//  b           in   WIDTH  subtrahend
//  busy        out  1      high while bits are being processed
//  done        out  1      one-cycle pulse: diff/borrow_out valid
//  diff        out  WIDTH  result a-b mod 2^WIDTH, held until next accepted start
//  borrow_out  out  1      final borrow: 1 iff a < b (unsigned)
//  ovf         out  1      signed overflow (only when SERIAL_SUB_OVF_EN defined)
// BEHAVIOUR
//  Reset is asynchronous and active-high.
//  - During rst: state=IDLE; busy, done, diff, borrow_out, ovf all 0.
//  - Internal shift registers and bit counter also cleared.
//  - Reset mid-operation aborts the operation; no done pulse is produced.
//  FSM states:
//  - IDLE: start=1 -> capture a,b into shift regs; borrow flop=0; cnt=0; go to SHIFT.
//  - SHIFT: busy=1. Each cycle, full_subtractor(x=a_sr[0], y=b_sr[0], bi=borrow) gives d,bo.
//    - d shifts into diff_sr MSB; a_sr and b_sr shift right; borrow<=bo; cnt++.
//    - When cnt==WIDTH-1 (last bit), go to DONE.
//  - DONE: done=1 for exactly this cycle. diff and borrow_out are updated on the DONE entry edge.
//    - start=1 -> capture and go to SHIFT (back-to-back allowed).
//    - Otherwise go to IDLE.
//  Latency: start sampled at edge k -> done high in cycle after edge k+WIDTH.
//  - Throughput is one result per WIDTH+1 cycles.
//  start while busy=1 is ignored; the operands are not re-captured.
//  diff/borrow_out change only on DONE entry; they are stable in IDLE and during SHIFT.
//  Arithmetic rules:
//  - diff = (a + ~b + 1) mod 2^WIDTH.
//  - borrow_out = borrow after MSB.
//  - Counter width = $clog2(WIDTH).
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//  - ovf output exists; registered alongside diff on DONE entry.
//  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using captured operands.
//  SERIAL_SUB_OVF_EN undefined:
//  - ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package serial_sub_pkg holds:
//  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t.
//  - localparam default WIDTH.
//  Sub-module full_subtractor (combinational):
//  - Inputs x, y, bi; outputs d, bo.
//  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
//  - Instantiated once.
// TESTING (WIDTH=8)
//  1. Simple subtraction: a=5, b=3, start 1 cycle
//     -> busy for 8 cycles, then done pulse; diff=0x02, borrow_out=0.
//  2. Unsigned underflow: a=3, b=5
//     -> diff=0xFE, borrow_out=1.
//  3. Full borrow ripple: a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
//     Then back-to-back start in DONE with a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
//  4. Start while busy: start at cycle 3 of SHIFT with a=0x10, b=0x01
//     -> ignored; result matches first operands; done pulses once.
//  5. Reset mid-operation: rst asserted mid-SHIFT
//     -> outputs 0 immediately, no done pulse, IDLE.
//     Next start a=9, b=4 -> diff=0x05.
//  6. Signed overflow (SERIAL_SUB_OVF_EN): a=0x80, b=0x01 -> diff=0x7F, ovf=1.
//     a=0x7F, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand/result bus for serial_subtractor.
// Signals: start,a,b (requester -> subtractor); busy,done,diff,borrow_out[,ovf] (subtractor -> requester).
// ovf is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = serial_sub_pkg::DEF_WIDTH);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell.
// Ports: x (minuend bit), y (subtrahend bit), bi (borrow in) -> d (difference), bo (borrow out).
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first, one bit per clock through a single full_subtractor.
// Ports: clk, rst (async, active-high), bus (serial_subtractor_if.slave: start,a,b in; busy,done,diff,borrow_out out).
// Optional: SERIAL_SUB_OVF_EN adds the registered signed-overflow output bus.ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    sub_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_q;
    logic [WIDTH-2:0] diff_sr;
    logic [WIDTH-1:0] diff_cat;
    logic [CW-1:0]    cnt;
    logic             borrow, borrow_q, d, bo, last, accept;

    full_subtractor u_fs (.x(a_sr[0]), .y(b_sr[0]), .bi(borrow), .d(d), .bo(bo));

    assign last     = cnt == CW'(WIDTH - 1);
    // start is honoured in IDLE and DONE only; while shifting it is ignored
    assign accept   = bus.start && state != SHIFT;
    // new bit enters at the top; after WIDTH shifts the LSB has reached bit 0
    assign diff_cat = {d, diff_sr};

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = state == SHIFT ? (last ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
    end

    assign bus.busy       = state == SHIFT;
    assign bus.done       = state == DONE;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;
    // on the last bit a_sr[0]/b_sr[0] hold the operand MSBs and d is the result MSB
    always_ff @(posedge clk or posedge rst)
        if (rst)                        ovf_q <= 1'b0;
        else if (state == SHIFT && last) ovf_q <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            borrow   <= 1'b0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (state == SHIFT) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            diff_sr <= diff_cat[WIDTH-1:1];
            borrow  <= bo;
            cnt     <= cnt + 1'b1;
            if (last) begin
                diff_q   <= diff_cat;
                borrow_q <= bo;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
    logic clk = 0;
    logic rst = 1;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_subtractor_if #(.WIDTH(8)) bus ();
    serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        bus.a = a;
        bus.b = b;
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        ok = bus.done === 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.busy !== 0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.diff !== 8'h00) begin n_err++; $display("FAIL reset_diff got %h want 00", bus.diff); end
        n_cmp++; if (bus.borrow_out !== 0) begin n_err++; $display("FAIL reset_borrow got %b want 0", bus.borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++; if (bus.ovf !== 0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
    endtask

    task automatic test_simple();
        int c; bit ok;
        launch(8'd5, 8'd3);
        n_cmp++; if (bus.busy !== 1) begin n_err++; $display("FAIL simple_busy got %b want 1", bus.busy); end
        wait_done(c, ok);
        n_cmp++; if (!ok || c != 8) begin n_err++; $display("FAIL simple_latency got %0d ok=%0d want 8", c, ok); end
        n_cmp++; if (bus.diff !== 8'h02) begin n_err++; $display("FAIL simple_diff got %h want 02", bus.diff); end
        n_cmp++; if (bus.borrow_out !== 0) begin n_err++; $display("FAIL simple_borrow got %b want 0", bus.borrow_out); end
        tick();
        n_cmp++; if (bus.done !== 0) begin n_err++; $display("FAIL simple_done_pulse got %b want 0", bus.done); end
        n_cmp++; if (bus.diff !== 8'h02) begin n_err++; $display("FAIL simple_hold got %h want 02", bus.diff); end
    endtask

    task automatic test_underflow();
        int c; bit ok;
        launch(8'd3, 8'd5);
        tick();
        n_cmp++; if (bus.diff !== 8'h02) begin n_err++; $display("FAIL underflow_stable got %h want 02", bus.diff); end
        wait_done(c, ok);
        n_cmp++; if (!ok || c != 7) begin n_err++; $display("FAIL underflow_latency got %0d ok=%0d want 7", c, ok); end
        n_cmp++; if (bus.diff !== 8'hFE) begin n_err++; $display("FAIL underflow_diff got %h want fe", bus.diff); end
        n_cmp++; if (bus.borrow_out !== 1) begin n_err++; $display("FAIL underflow_borrow got %b want 1", bus.borrow_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int c; bit ok;
        launch(8'h00, 8'hFF);
        wait_done(c, ok);
        n_cmp++; if (!ok || bus.diff !== 8'h01) begin n_err++; $display("FAIL ripple_diff got %h ok=%0d want 01", bus.diff, ok); end
        n_cmp++; if (bus.borrow_out !== 1) begin n_err++; $display("FAIL ripple_borrow got %b want 1", bus.borrow_out); end
        launch(8'hFF, 8'hFF);
        n_cmp++; if (bus.busy !== 1) begin n_err++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
        n_cmp++; if (bus.diff !== 8'h01) begin n_err++; $display("FAIL b2b_hold got %h want 01", bus.diff); end
        wait_done(c, ok);
        n_cmp++; if (!ok || c != 8) begin n_err++; $display("FAIL b2b_latency got %0d ok=%0d want 8", c, ok); end
        n_cmp++; if (bus.diff !== 8'h00) begin n_err++; $display("FAIL b2b_diff got %h want 00", bus.diff); end
        n_cmp++; if (bus.borrow_out !== 0) begin n_err++; $display("FAIL b2b_borrow got %b want 0", bus.borrow_out); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int c; bit ok; int dones;
        launch(8'h20, 8'h07);
        tick();
        tick();
        bus.a = 8'h10;
        bus.b = 8'h01;
        bus.start = 1;
        tick();
        bus.start = 0;
        wait_done(c, ok);
        n_cmp++; if (!ok || c != 5) begin n_err++; $display("FAIL busy_start_latency got %0d ok=%0d want 5", c, ok); end
        n_cmp++; if (bus.diff !== 8'h19) begin n_err++; $display("FAIL busy_start_diff got %h want 19", bus.diff); end
        n_cmp++; if (bus.borrow_out !== 0) begin n_err++; $display("FAIL busy_start_borrow got %b want 0", bus.borrow_out); end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 0 || bus.busy !== 0) begin n_err++; $display("FAIL busy_start_single_done got extra=%0d busy=%b want 0/0", dones, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int c; bit ok; int dones;
        launch(8'h55, 8'h11);
        tick();
        tick();
        rst = 1;
        #1;
        n_cmp++; if (bus.busy !== 0 || bus.done !== 0) begin n_err++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        n_cmp++; if (bus.diff !== 8'h00 || bus.borrow_out !== 0) begin n_err++; $display("FAIL rstmid_data got %h/%b want 00/0", bus.diff, bus.borrow_out); end
        tick();
        rst = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL rstmid_idle got %0d active cycles want 0", dones); end
        launch(8'd9, 8'd4);
        wait_done(c, ok);
        n_cmp++; if (!ok || bus.diff !== 8'h05) begin n_err++; $display("FAIL rstmid_next got %h ok=%0d want 05", bus.diff, ok); end
        tick();
    endtask

    task automatic test_signed();
        int c; bit ok;
        launch(8'h80, 8'h01);
        wait_done(c, ok);
        n_cmp++; if (!ok || bus.diff !== 8'h7F || bus.borrow_out !== 0) begin n_err++; $display("FAIL signed_neg got %h/%b want 7f/0", bus.diff, bus.borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++; if (bus.ovf !== 1) begin n_err++; $display("FAIL ovf_set got %b want 1", bus.ovf); end
`endif
        tick();
        launch(8'h7F, 8'h01);
        wait_done(c, ok);
        n_cmp++; if (!ok || bus.diff !== 8'h7E) begin n_err++; $display("FAIL signed_pos got %h want 7e", bus.diff); end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++; if (bus.ovf !== 0) begin n_err++; $display("FAIL ovf_clear got %b want 0", bus.ovf); end
`endif
        tick();
    endtask

    initial begin
        bus.start = 0;
        bus.a = '0;
        bus.b = '0;
        #1;
        test_reset();
        tick();
        tick();
        rst = 0;
        tick();
        test_simple();
        test_underflow();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_signed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
